// File: rtl/timer_prog.sv
// Programmable multi-channel interval timer: NCH down-counters sharing one prescaler,
// one-shot or periodic, each with a maskable level interrupt held until acknowledged.
module timer_prog #(
    parameter  int NCH    = 3,
    parameter  int DATA_W = 8,
    parameter  int PRESC  = 2,
    localparam int AW     = 2 + $clog2(NCH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    input  logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    irq
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chState_t;

    chState_t          state_r [NCH];
    logic [DATA_W-1:0] load_r  [NCH];
    logic [DATA_W-1:0] count_r [NCH];
    logic [NCH-1:0]    mode_r;
    logic [NCH-1:0]    ien_r;
    logic [NCH-1:0]    pend_r;
    logic [PW-1:0]     prescCnt_r;

    logic              tick_s;
    logic [AW-1:0]     chIdx_s;
    logic [CW-1:0]     chNum_s;
    logic [1:0]        regSel_s;
    logic              chValid_s;
    logic [NCH-1:0]    wrLoad_s;
    logic [NCH-1:0]    wrCtrl_s;
    logic [DATA_W-1:0] ctrlWord_s [NCH];
    logic [DATA_W-1:0] rdSel_s;

    // Address decode, per-channel write strobes and CTRL read-back words.
    always_comb begin
        chIdx_s   = addr >> 2;
        chNum_s   = chIdx_s[CW-1:0];
        regSel_s  = addr[1:0];
        chValid_s = (chIdx_s < AW'(NCH));
        tick_s    = (prescCnt_r == PW'(PRESC - 1));
        wrLoad_s  = {NCH{1'b0}};
        wrCtrl_s  = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            wrLoad_s[i]   = we & chValid_s & (chIdx_s == AW'(i)) & (regSel_s == 2'd0);
            wrCtrl_s[i]   = we & chValid_s & (chIdx_s == AW'(i)) & (regSel_s == 2'd1);
            ctrlWord_s[i] = {{(DATA_W-4){1'b0}}, pend_r[i], ien_r[i], mode_r[i],
                             (state_r[i] == RUN)};
        end
    end

    // Read-data mux; unmapped channels and reg 3 read as zero.
    always_comb begin
        rdSel_s = {DATA_W{1'b0}};
        if (!chValid_s) begin
            rdSel_s = {DATA_W{1'b0}};
        end else begin
            case (regSel_s)
                2'd0:    rdSel_s = load_r[chNum_s];
                2'd1:    rdSel_s = ctrlWord_s[chNum_s];
                2'd2:    rdSel_s = count_r[chNum_s];
                default: rdSel_s = {DATA_W{1'b0}};
            endcase
        end
    end

    assign irq = pend_r & ien_r;

    // Shared prescaler, wraps after PRESC-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescCnt_r <= {PW{1'b0}};
        end else if (tick_s) begin
            prescCnt_r <= {PW{1'b0}};
        end else begin
            prescCnt_r <= prescCnt_r + PW'(1);
        end
    end

    // Registered read port, one cycle after the address is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= {DATA_W{1'b0}};
        end else begin
            rdata <= rdSel_s;
        end
    end

    // Channel FSMs; a CTRL write takes priority over a same-cycle tick, but an
    // expiry on that tick still latches pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_r[i] <= IDLE;
                load_r[i]  <= {DATA_W{1'b0}};
                count_r[i] <= {DATA_W{1'b0}};
            end
            mode_r <= {NCH{1'b0}};
            ien_r  <= {NCH{1'b0}};
            pend_r <= {NCH{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if ((state_r[i] == RUN) && tick_s && (count_r[i] == {DATA_W{1'b0}})) begin
                    pend_r[i] <= 1'b1;
                end else if (ack[i]) begin
                    pend_r[i] <= 1'b0;
                end

                if (wrLoad_s[i]) begin
                    load_r[i] <= wdata;
                end

                if (wrCtrl_s[i]) begin
                    mode_r[i] <= wdata[1];
                    ien_r[i]  <= wdata[2];
                    if (wdata[0]) begin
                        state_r[i] <= RUN;
                        count_r[i] <= load_r[i];
                    end else begin
                        state_r[i] <= IDLE;
                    end
                end else begin
                    case (state_r[i])
                        RUN: begin
                            if (tick_s) begin
                                if (count_r[i] != {DATA_W{1'b0}}) begin
                                    count_r[i] <= count_r[i] - DATA_W'(1);
                                end else if (mode_r[i]) begin
                                    count_r[i] <= load_r[i];
                                end else begin
                                    state_r[i] <= DONE;
                                end
                            end
                        end
                        IDLE:    state_r[i] <= IDLE;
                        DONE:    state_r[i] <= DONE;
                        default: state_r[i] <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule
